// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types and constants for the HPM overflow controller
package ariane_pkg;
   typedef enum logic [1:0] {IDLE, PEND, SERVICE} perf_ovf_state_e;
   localparam int HPM_FIRST_IDX = 3;
endpackage

// File: rtl/perf_ovf_popcnt_sat.sv
// perf_ovf_popcnt_sat: adds the population count of bits_i to cnt_i, saturating at all-ones
//   bits_i : event bits to count
//   cnt_i  : current tally
//   cnt_o  : updated tally, clamped at all-ones
module perf_ovf_popcnt_sat #(
   parameter int N = 29,
   parameter int W = 16
) (
   input  logic [N-1:0] bits_i,
   input  logic [W-1:0] cnt_i,
   output logic [W-1:0] cnt_o
);
   localparam int CW = $clog2(N + 1);
   logic [W+CW-1:0] sum;
   always_comb begin
      sum = {{CW{1'b0}}, cnt_i};
      for (int i = 0; i < N; i++) sum = sum + {{(W+CW-1){1'b0}}, bits_i[i]};
      cnt_o = |sum[W+CW-1:W] ? {W{1'b1}} : sum[W-1:0];
   end
endmodule

// File: rtl/perf_ovf_ctrl.sv
// perf_ovf_ctrl: sticky HPM overflow status, overflow interrupt FSM and optional counter freeze
//   clk_i, rst_i    : clock, synchronous active-high reset
//   cnt_wrap_i      : per-counter wrap pulse (index 0 = mhpmcounter3)
//   inhibit_i       : software mcountinhibit bits
//   ovf_ie_i        : per-counter overflow interrupt enable
//   ovf_clr_i       : write-1-to-clear for sticky overflow bits
//   irq_ack_i       : trap entry for the overflow interrupt
//   inhibit_o       : effective inhibit mask to the counter block
//   ovf_o           : sticky overflow status
//   irq_o           : overflow interrupt request
//   freeze_o        : counters frozen
//   ovf_cnt_o       : saturating tally of overflow-set events
//   Freeze logic exists only when PERF_OVF_FREEZE_EN is defined.
module perf_ovf_ctrl
   import ariane_pkg::*;
#(
   parameter int NumCounters = 29,
   parameter int OvfCntWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumCounters-1:0] cnt_wrap_i,
   input  logic [NumCounters-1:0] inhibit_i,
   input  logic [NumCounters-1:0] ovf_ie_i,
   input  logic [NumCounters-1:0] ovf_clr_i,
   input  logic                   irq_ack_i,
   output logic [NumCounters-1:0] inhibit_o,
   output logic [NumCounters-1:0] ovf_o,
   output logic                   irq_o,
   output logic                   freeze_o,
   output logic [OvfCntWidth-1:0] ovf_cnt_o
);
   perf_ovf_state_e state_q, state_d;
   logic [NumCounters-1:0] ovf_q, ovf_d, new_set;
   logic [OvfCntWidth-1:0] cnt_q, cnt_d;
   logic pend_any;
   assign new_set  = cnt_wrap_i & ~ovf_q;
   // a wrap wins over a same-cycle clear
   assign ovf_d    = (ovf_q & ~ovf_clr_i) | cnt_wrap_i;
   assign pend_any = |(ovf_d & ovf_ie_i);
   perf_ovf_popcnt_sat #(.N(NumCounters), .W(OvfCntWidth)) u_popcnt (
      .bits_i(new_set),
      .cnt_i (cnt_q),
      .cnt_o (cnt_d)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = |(new_set & ovf_ie_i) ? PEND : IDLE;
         PEND:    state_d = irq_ack_i ? SERVICE : (pend_any ? PEND : IDLE);
         SERVICE: state_d = pend_any ? SERVICE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ovf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end
   assign irq_o     = (state_q == PEND);
   assign ovf_o     = ovf_q;
   assign ovf_cnt_o = cnt_q;
`ifdef PERF_OVF_FREEZE_EN
   logic freeze_q;
   always_ff @(posedge clk_i) freeze_q <= rst_i ? 1'b0 : (state_d != IDLE);
   assign freeze_o  = freeze_q;
   // the mask drops as soon as reset is asserted, before the register clears
   assign inhibit_o = inhibit_i | {NumCounters{freeze_q & ~rst_i}};
`else
   assign freeze_o  = 1'b0;
   assign inhibit_o = inhibit_i;
`endif
endmodule

// File: tb/tb_perf_ovf_ctrl.sv
// tb_perf_ovf_ctrl: directed self-checking bench for perf_ovf_ctrl
module tb_perf_ovf_ctrl;
   localparam int N = 29;
   localparam int W = 16;
`ifdef PERF_OVF_FREEZE_EN
   localparam bit FRZ = 1'b1;
`else
   localparam bit FRZ = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_i;
   logic [N-1:0] cnt_wrap_i, inhibit_i, ovf_ie_i, ovf_clr_i;
   logic irq_ack_i;
   logic [N-1:0] inhibit_o, ovf_o;
   logic irq_o, freeze_o;
   logic [W-1:0] ovf_cnt_o;
   int checks = 0;
   int errors = 0;
   perf_ovf_ctrl #(.NumCounters(N), .OvfCntWidth(W)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .cnt_wrap_i(cnt_wrap_i),
      .inhibit_i (inhibit_i),
      .ovf_ie_i  (ovf_ie_i),
      .ovf_clr_i (ovf_clr_i),
      .irq_ack_i (irq_ack_i),
      .inhibit_o (inhibit_o),
      .ovf_o     (ovf_o),
      .irq_o     (irq_o),
      .freeze_o  (freeze_o),
      .ovf_cnt_o (ovf_cnt_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [N-1:0] frz_mask(input bit on);
      return on ? {N{1'b1}} : '0;
   endfunction
   initial begin
      rst_i = 1'b1; cnt_wrap_i = '0; ovf_clr_i = '0; irq_ack_i = 1'b0;
      inhibit_i = 29'h00A5;
      ovf_ie_i = ~(29'd1 << 10);
      step(); step();
      chk("rst_ovf", ovf_o, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_cnt", ovf_cnt_o, 0);
      chk("rst_frz", freeze_o, 0);
      chk("rst_inh", inhibit_o, inhibit_i);
      rst_i = 1'b0;
      irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
      chk("ack_idle_irq", irq_o, 0);
      cnt_wrap_i = 29'd1; step(); cnt_wrap_i = '0;
      chk("w0_ovf", ovf_o, 1);
      chk("w0_irq", irq_o, 1);
      chk("w0_cnt", ovf_cnt_o, 1);
      chk("w0_frz", freeze_o, FRZ);
      chk("w0_inh", inhibit_o, inhibit_i | frz_mask(FRZ));
      irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
      chk("ack_irq", irq_o, 0);
      chk("ack_frz", freeze_o, FRZ);
      cnt_wrap_i = 29'h20; ovf_clr_i = 29'h20; step(); cnt_wrap_i = '0; ovf_clr_i = '0;
      chk("wc5_ovf", ovf_o, 29'h21);
      chk("wc5_cnt", ovf_cnt_o, 2);
      chk("wc5_irq", irq_o, 0);
      ovf_clr_i = 29'h21; step(); ovf_clr_i = '0;
      chk("clr_ovf", ovf_o, 0);
      chk("clr_frz", freeze_o, 0);
      chk("clr_inh", inhibit_o, inhibit_i);
      cnt_wrap_i = 29'd1 << 10; step(); cnt_wrap_i = '0;
      chk("noie_ovf", ovf_o, 29'd1 << 10);
      chk("noie_irq", irq_o, 0);
      chk("noie_cnt", ovf_cnt_o, 3);
      step();
      chk("noie_irq2", irq_o, 0);
      chk("noie_frz", freeze_o, 0);
      ovf_clr_i = 29'd1 << 10; step(); ovf_clr_i = '0;
      ovf_ie_i = '0;
      for (int i = 0; i < 2260; i++) begin
         cnt_wrap_i = (i == 2259) ? 29'hFFFFF : '1;
         step();
         cnt_wrap_i = '0; ovf_clr_i = '1;
         step();
         ovf_clr_i = '0;
      end
      chk("pump_cnt", ovf_cnt_o, 16'hFFFE);
      chk("pump_irq", irq_o, 0);
      ovf_ie_i = '1;
      cnt_wrap_i = 29'hE; step(); cnt_wrap_i = '0;
      chk("sat_cnt", ovf_cnt_o, 16'hFFFF);
      chk("sat_irq", irq_o, 1);
      chk("sat_ovf", ovf_o, 29'hE);
      ovf_clr_i = 29'hE; step(); ovf_clr_i = '0;
      chk("swclr_irq", irq_o, 0);
      chk("swclr_frz", freeze_o, 0);
      cnt_wrap_i = 29'd1; step(); cnt_wrap_i = '0;
      chk("re_irq", irq_o, 1);
      chk("re_cnt", ovf_cnt_o, 16'hFFFF);
      irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
      cnt_wrap_i = 29'h10; step(); cnt_wrap_i = '0;
      chk("svc_irq", irq_o, 0);
      chk("svc_frz", freeze_o, FRZ);
      chk("svc_ovf", ovf_o, 29'h11);
      rst_i = 1'b1; #1;
      chk("rsta_inh", inhibit_o, inhibit_i);
      step(); rst_i = 1'b0;
      chk("rsvc_ovf", ovf_o, 0);
      chk("rsvc_irq", irq_o, 0);
      chk("rsvc_frz", freeze_o, 0);
      chk("rsvc_cnt", ovf_cnt_o, 0);
      chk("rsvc_inh", inhibit_o, inhibit_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
